data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra response delay in cycles (legal 0..7).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port read_enable  input  1  read request from initiator.
REQ-007 SHALL have port write_enable  input  1  write request from initiator.
REQ-008 SHALL have port address  input  32  byte address of the request.
REQ-009 SHALL have port write_data  input  32  store data, lane-aligned.
REQ-010 SHALL have port byte_enable  input  4  per-lane write mask, bit i = bits 8i+7:8i.
REQ-011 SHALL have port read_data  output  32  load data, valid only while ready=1.
REQ-012 SHALL have port ready  output  1  one-cycle response strobe.
REQ-013 SHALL have port error  output  1  response is a fault, valid only while ready=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-015 IDLE: request accepted on the rising edge where read_enable|write_enable=1; address, write_data, byte_enable, and request type latched.
REQ-016 IDLE -> WAIT on acceptance when WAIT_STATES>0, loading the wait counter with WAIT_STATES-1; IDLE -> RESPOND when WAIT_STATES=0.
REQ-017 WAIT: counter decrements each cycle; WAIT -> RESPOND when counter=0.
REQ-018 RESPOND: ready=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-019 Latency from acceptance edge to ready high SHALL be WAIT_STATES+1 cycles; back-to-back requests SHALL incur one IDLE cycle between responses.
REQ-020 Inputs SHALL be ignored outside IDLE; the initiator holds the request until ready.
REQ-021 Word index = (address - BASE_ADDR) >> 2; address[1:0] ignored.
REQ-022 In range means BASE_ADDR <= address < BASE_ADDR + 4*DEPTH_WORDS, compared in 33 bits without wrap-around.
REQ-023 Write in range: lanes with byte_enable[i]=1 updated on the WAIT/IDLE -> RESPOND edge; other lanes unchanged; byte_enable=0 is legal and writes nothing.
REQ-024 Read in range: read_data = stored word at the index during RESPOND; a read after a write to the same word returns the written data.
REQ-025 Out-of-range access: error=1 with ready, no write, read_data=0.
REQ-026 read_enable and write_enable both high at acceptance: error=1, no write, read_data=0.
REQ-027 Outside RESPOND: read_data=0, ready=0, error=0.

Reset
REQ-028 While reset=0: state=IDLE, wait counter=0, ready=0, error=0, read_data=0, latched request cleared, asynchronously.
REQ-029 Reset mid-WAIT SHALL drop the pending request: no write, no response.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-032 The state enum, default parameter values, and the WAIT_STATES width constant (3 bits) SHALL reside in the shared constants package.
REQ-033 Storage SHALL be a sub-module bus_ram_array: a single-port, byte-enable-write, combinational-read array of DEPTH_WORDS x 32.
REQ-034 The FSM, range check, and output gating SHALL reside in data_bus_responder.

Verification
REQ-035 WAIT_STATES=1: write 32'hDEADBEEF to BASE_ADDR+8 with be=4'hF, then read it -> ready 2 cycles after each acceptance, read_data=32'hDEADBEEF, error=0.
REQ-036 Partial write: word at BASE_ADDR+4 holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101 -> a later read returns 32'h11BB33DD.
REQ-037 Range edges: read at BASE_ADDR+4*DEPTH_WORDS-4 -> error=0; reads at BASE_ADDR+4*DEPTH_WORDS, BASE_ADDR-4, and 32'hFFFF_FFFC -> error=1, read_data=0.
REQ-038 read_enable and write_enable both high at BASE_ADDR -> error=1, and a subsequent read shows the word unchanged.
REQ-039 WAIT_STATES=3: assert reset for one cycle during WAIT of a write 32'h5 -> no ready pulse, word keeps its old value, next read completes normally 4 cycles after acceptance.
REQ-040 WAIT_STATES=0 with continuous read requests -> ready toggles 1,0,1,0 and data tracks the address sequence.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_responder_pkg
// Shared constants for the data bus responder: default parameter values,
// wait-counter width and the FSM state encoding.
// No ports.
// -----------------------------------------------------------------------------
package data_bus_responder_pkg;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0001_0000;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_WAIT_STATES = 1;

    // Width of the wait-state counter; WAIT_STATES is legal in 0..7.
    localparam int unsigned WS_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

endpackage

// File: rtl/data_bus_responder_if.sv
// -----------------------------------------------------------------------------
// data_bus_responder_if
// Request/response bundle between an initiator (master) and the responder
// (slave).
//   read_enable, write_enable : request strobes, held until ready
//   address                   : byte address of the request
//   write_data, byte_enable   : store data and per-lane write mask
//   read_data                 : load data, valid only while ready=1
//   ready                     : one-cycle response strobe
//   error                     : response is a fault, valid only while ready=1
// -----------------------------------------------------------------------------
interface data_bus_responder_if;

    logic        read_enable;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic [31:0] read_data;
    logic        ready;
    logic        error;

    modport master (
        output read_enable, write_enable, address, write_data, byte_enable,
        input  read_data, ready, error
    );

    modport slave (
        input  read_enable, write_enable, address, write_data, byte_enable,
        output read_data, ready, error
    );

endinterface

// File: rtl/data_bus_responder_ram_array.sv
// -----------------------------------------------------------------------------
// bus_ram_array
// Single-port DEPTH_WORDS x 32 storage with byte-lane write enables and a
// combinational read of the addressed word. Contents are never reset.
//   clock   : write clock, rising edge
//   wr_en   : commit write on this edge
//   index   : word index for both read and write
//   wr_data : store data, lane-aligned
//   wr_be   : lane mask, bit i covers bits 8i+7:8i
//   rd_data : word currently at index
// -----------------------------------------------------------------------------
module bus_ram_array
    import data_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[index][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem[index];

endmodule

// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
// Memory-mapped word store answering single requests after a fixed number
// of wait states, with range checking and fault reporting.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of data_bus_responder_if
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for read_enable|write_enable; request latched on accept
// S_WAIT     | counting down wait states
// S_RESPOND  | ready (and error/read_data) driven for exactly one cycle
// -----------------------------------------------------------------------------
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                 clock,
    input  logic                 reset,
    data_bus_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_WAIT    = ST_WAIT;
    localparam logic [1:0] S_RESPOND = ST_RESPOND;

    // Window bounds held in 33 bits so the top of the window never wraps.
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * DEPTH_WORDS);

    localparam logic [WS_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WS_W'(WAIT_STATES - 1);

    logic [1:0]      state;
    logic [WS_W-1:0] wait_cnt;
    logic            req_rd;
    logic            req_wr;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [3:0]      req_be;

    logic            in_idle;
    logic            accept;
    logic            to_respond;
    logic            sel_rd;
    logic            sel_wr;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_be;
    logic            in_range;
    logic [AW-1:0]   word_index;
    logic            ram_we;
    logic [31:0]     ram_rdata;
    logic            respond;
    logic            fault;

    assign in_idle = (state == S_IDLE);
    assign accept  = in_idle && (bus.read_enable || bus.write_enable);

    // With zero wait states the write commits on the acceptance edge itself,
    // before the request is latched, so the array sees the live bus in IDLE.
    assign sel_rd    = in_idle ? bus.read_enable  : req_rd;
    assign sel_wr    = in_idle ? bus.write_enable : req_wr;
    assign sel_addr  = in_idle ? bus.address      : req_addr;
    assign sel_wdata = in_idle ? bus.write_data   : req_wdata;
    assign sel_be    = in_idle ? bus.byte_enable  : req_be;

    assign in_range   = ({1'b0, sel_addr} >= ADDR_LO) && ({1'b0, sel_addr} < ADDR_HI);
    assign word_index = AW'((sel_addr - BASE_ADDR) >> 2);

    assign to_respond = (accept && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (wait_cnt == '0));
    assign ram_we     = to_respond && sel_wr && !sel_rd && in_range;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_rd    <= bus.read_enable;
                        req_wr    <= bus.write_enable;
                        req_addr  <= bus.address;
                        req_wdata <= bus.write_data;
                        req_be    <= bus.byte_enable;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESPOND;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - WS_W'(1);
                    end
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    bus_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .index   (word_index),
        .wr_data (sel_wdata),
        .wr_be   (sel_be),
        .rd_data (ram_rdata)
    );

    assign respond = (state == S_RESPOND);
    assign fault   = !in_range || (req_rd && req_wr);

    assign bus.ready     = respond;
    assign bus.error     = respond && fault;
    assign bus.read_data = (respond && !fault && req_rd) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_bus_responder.sv
// Three responders share one clock: dut0 WAIT_STATES=1, dut1 WAIT_STATES=3,
// dut2 WAIT_STATES=0. Expected responses are queued when a request is driven
// and popped when ready is seen.
module tb_data_bus_responder;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 1024;
    localparam int          NDUT  = 3;

    typedef struct {
        int          dut;
        logic        err;
        logic [31:0] data;
        bit          chk_data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [NDUT-1:0] rst_n;
    logic [NDUT-1:0] rd_s;
    logic [NDUT-1:0] wr_s;
    logic [31:0]     addr_s  [NDUT];
    logic [31:0]     wdata_s [NDUT];
    logic [3:0]      be_s    [NDUT];
    logic [NDUT-1:0] ready_w;
    logic [NDUT-1:0] error_w;
    logic [31:0]     rdata_w [NDUT];
    logic [31:0]     mem_m   [NDUT][DEPTH];

    data_bus_responder_if bus0 ();
    data_bus_responder_if bus1 ();
    data_bus_responder_if bus2 ();

    assign bus0.read_enable = rd_s[0];  assign bus0.write_enable = wr_s[0];
    assign bus0.address = addr_s[0];    assign bus0.write_data = wdata_s[0];
    assign bus0.byte_enable = be_s[0];
    assign bus1.read_enable = rd_s[1];  assign bus1.write_enable = wr_s[1];
    assign bus1.address = addr_s[1];    assign bus1.write_data = wdata_s[1];
    assign bus1.byte_enable = be_s[1];
    assign bus2.read_enable = rd_s[2];  assign bus2.write_enable = wr_s[2];
    assign bus2.address = addr_s[2];    assign bus2.write_data = wdata_s[2];
    assign bus2.byte_enable = be_s[2];

    assign ready_w[0] = bus0.ready;  assign error_w[0] = bus0.error;  assign rdata_w[0] = bus0.read_data;
    assign ready_w[1] = bus1.ready;  assign error_w[1] = bus1.error;  assign rdata_w[1] = bus1.read_data;
    assign ready_w[2] = bus2.ready;  assign error_w[2] = bus2.error;  assign rdata_w[2] = bus2.read_data;

    data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1))
        dut0 (.clock(clock), .reset(rst_n[0]), .bus(bus0));
    data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3))
        dut1 (.clock(clock), .reset(rst_n[1]), .bus(bus1));
    data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0))
        dut2 (.clock(clock), .reset(rst_n[2]), .bus(bus2));

    function automatic int ws_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: range check, fault rules and byte-lane merge.
    function automatic exp_t model_req(int d, bit r, bit w, logic [31:0] a,
                                       logic [31:0] wd, logic [3:0] be);
        exp_t   e;
        longint la;
        bit     inr;
        int     idx;
        la  = longint'(a);
        inr = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
        idx = int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
        e.dut      = d;
        e.lat      = ws_of(d) + 1;
        e.chk_data = 1'b1;
        e.data     = '0;
        if (!inr || (r && w)) begin
            e.err = 1'b1;
        end else if (r) begin
            e.err  = 1'b0;
            e.data = mem_m[d][idx];
        end else begin
            e.err      = 1'b0;
            e.chk_data = 1'b0;
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
        return e;
    endfunction

    // One complete transaction: drive in IDLE, hold until ready, compare,
    // then step over the RESPOND->IDLE edge so the next call starts in IDLE.
    task automatic bus_xfer(int d, bit r, bit w, logic [31:0] a,
                            logic [31:0] wd, logic [3:0] be, string tag);
        exp_t e;
        int   k;
        sb.push_back(model_req(d, r, w, a, wd, be));
        @(negedge clock);
        rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = be;
        @(posedge clock);
        k = 0;
        #1;
        while (!ready_w[d] && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        check_eq({tag, "_ready"}, 32'(ready_w[d]), 32'd1);
        e = sb.pop_front();
        if (ready_w[d]) begin
            check_eq({tag, "_err"}, 32'(error_w[d]), 32'(e.err));
            check_eq({tag, "_lat"}, 32'(k + 1), 32'(e.lat));
            if (e.chk_data) check_eq({tag, "_data"}, rdata_w[d], e.data);
            @(posedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] a;
        logic [31:0] v;
        logic [3:0]  be;
        bit          saw;
        int          nxt;

        rst_n = '0;
        rd_s  = '0;
        wr_s  = '0;
        for (int d = 0; d < NDUT; d++) begin
            addr_s[d] = '0; wdata_s[d] = '0; be_s[d] = '0;
        end

        #12;
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("rst_ready%0d", d), 32'(ready_w[d]), 32'd0);
            check_eq($sformatf("rst_error%0d", d), 32'(error_w[d]), 32'd0);
            check_eq($sformatf("rst_rdata%0d", d), rdata_w[d], 32'd0);
        end
        @(posedge clock);
        #2 rst_n = '1;

        // dut0, one wait state: basic write/read, partial writes, range edges
        bus_xfer(0, 0, 1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, "wr_deadbeef");
        bus_xfer(0, 1, 0, BASE + 32'h8, 32'h0, 4'h0, "rd_deadbeef");
        bus_xfer(0, 1, 0, BASE + 32'hB, 32'h0, 4'h0, "rd_lowbits");
        bus_xfer(0, 0, 1, BASE + 32'h4, 32'h1122_3344, 4'hF, "wr_base4");
        bus_xfer(0, 0, 1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, "wr_partial");
        bus_xfer(0, 1, 0, BASE + 32'h4, 32'h0, 4'h0, "rd_partial");
        bus_xfer(0, 0, 1, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, "wr_be0");
        bus_xfer(0, 1, 0, BASE + 32'h4, 32'h0, 4'h0, "rd_be0");
        bus_xfer(0, 0, 1, BASE + 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 4'hF, "wr_last");
        bus_xfer(0, 1, 0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'h0, "rd_last");
        bus_xfer(0, 1, 0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, "rd_above");
        bus_xfer(0, 1, 0, BASE - 32'h4, 32'h0, 4'h0, "rd_below");
        bus_xfer(0, 1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, "rd_top");
        bus_xfer(0, 0, 1, BASE, 32'h1234_5678, 4'hF, "wr_base");
        bus_xfer(0, 1, 1, BASE, 32'h0000_0000, 4'hF, "rdwr_both");
        bus_xfer(0, 0, 1, BASE + 32'(4 * DEPTH), 32'h0000_0000, 4'hF, "wr_above");
        bus_xfer(0, 1, 0, BASE, 32'h0, 4'h0, "rd_base");

        for (int i = 0; i < 5; i++) begin
            a  = BASE + 32'(4 * $urandom_range(16, DEPTH - 2));
            v  = $urandom;
            be = 4'($urandom_range(0, 15));
            bus_xfer(0, 0, 1, a, v, 4'hF, $sformatf("rnd_wr%0d", i));
            bus_xfer(0, 0, 1, a, ~v, be, $sformatf("rnd_pw%0d", i));
            bus_xfer(0, 1, 0, a, 32'h0, 4'h0, $sformatf("rnd_rd%0d", i));
        end

        // dut1, three wait states: reset during WAIT drops a pending write
        bus_xfer(1, 0, 1, BASE + 32'h10, 32'h0BAD_F00D, 4'hF, "ws3_wr");
        bus_xfer(1, 1, 0, BASE + 32'h10, 32'h0, 4'h0, "ws3_rd");
        @(negedge clock);
        rd_s[1] = 1'b0; wr_s[1] = 1'b1; addr_s[1] = BASE + 32'h10;
        wdata_s[1] = 32'h5; be_s[1] = 4'hF;
        @(posedge clock);
        @(negedge clock);
        rst_n[1] = 1'b0;
        wr_s[1]  = 1'b0;
        saw = 1'b0;
        @(posedge clock);
        #1 if (ready_w[1]) saw = 1'b1;
        check_eq("ws3_rst_rdata", rdata_w[1], 32'd0);
        #1 rst_n[1] = 1'b1;
        bus_xfer(1, 1, 0, BASE + 32'h10, 32'h0, 4'h0, "ws3_rd_after_rst");
        repeat (6) begin
            @(posedge clock);
            #1 if (ready_w[1]) saw = 1'b1;
        end
        check_eq("ws3_no_stray_ready", 32'(saw), 32'd0);

        // dut2, zero wait states: continuous reads alternate ready 1,0,1,0
        for (int i = 0; i < 4; i++)
            bus_xfer(2, 0, 1, BASE + 32'(32 + 4 * i), 32'hA5A5_0000 + 32'(i * 17), 4'hF,
                     $sformatf("ws0_wr%0d", i));
        @(negedge clock);
        rd_s[2] = 1'b1; wr_s[2] = 1'b0; be_s[2] = 4'h0; addr_s[2] = BASE + 32'd32;
        sb.push_back(model_req(2, 1, 0, BASE + 32'd32, 32'h0, 4'h0));
        nxt = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("ws0_ready_c%0d", c), 32'(ready_w[2]), 32'(c % 2 == 0));
            if (ready_w[2] && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq($sformatf("ws0_data_c%0d", c), rdata_w[2], e.data);
                check_eq($sformatf("ws0_err_c%0d", c), 32'(error_w[2]), 32'(e.err));
                if (nxt < 4) begin
                    addr_s[2] = BASE + 32'(32 + 4 * nxt);
                    sb.push_back(model_req(2, 1, 0, addr_s[2], 32'h0, 4'h0));
                    nxt++;
                end
            end
        end
        rd_s[2] = 1'b0;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
